// File: rtl/edge_window_pipe_if.sv
// Pixel stream bundle for edge_window_pipe: input beats, per-frame
// configuration and the resolved output pixel.
interface edge_window_pipe_if #(
    parameter int CH_W   = 4,
    parameter int NUM_CH = 3,
    parameter int CNT_W  = $clog2(NUM_CH + 1)
);
    logic                     pixInValid;
    logic                     pixInSof;
    logic [NUM_CH*CH_W-1:0]   pixIn;
    logic [1:0]               mode;
    logic [CH_W+2:0]          edgeThresh;
    logic [CNT_W-1:0]         minChannels;
    logic                     shiftBrightness;
    logic [NUM_CH*CH_W-1:0]   pixOut;
    logic                     pixOutValid;
    logic                     pixOutSof;

    // Source side: drives the stream and configuration, observes the result.
    modport master (
        output pixInValid, pixInSof, pixIn, mode, edgeThresh, minChannels, shiftBrightness,
        input  pixOut, pixOutValid, pixOutSof
    );

    // Pipeline side.
    modport slave (
        input  pixInValid, pixInSof, pixIn, mode, edgeThresh, minChannels, shiftBrightness,
        output pixOut, pixOutValid, pixOutSof
    );
endinterface

// File: rtl/edge_window_pipe.sv
// Streaming 3x3 Sobel resolver: two line buffers build the window from a
// raster stream, then gradients, magnitude and the output mux run in a
// fixed three-register pipeline (window, gradients, output).
module edge_window_pipe #(
    parameter int CH_W   = 4,
    parameter int NUM_CH = 3,
    parameter int LINE_W = 640,
    parameter int CNT_W  = $clog2(NUM_CH + 1)
) (
    input  logic              clk25,
    input  logic              rst_n,
    edge_window_pipe_if.slave bus
);
    localparam int PIX_W = NUM_CH * CH_W;
    localparam int MAG_W = CH_W + 3;
    localparam int COL_W = $clog2(LINE_W);
    localparam int IDX_W = $clog2(LINE_W + 2);

    typedef enum logic [1:0] {WAIT_SOF, FILL, RUN} state_t;

    // Line buffers: lb0 holds the previous row, lb1 the row before that.
    logic [PIX_W-1:0] lb0_mem [LINE_W];
    logic [PIX_W-1:0] lb1_mem [LINE_W];
    logic [PIX_W-1:0] lb0_rd_q, lb1_rd_q;

    // Frame control.
    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             row0_q, row0_d;
    logic             wb_en_q, wb_en_d;
    logic [COL_W-1:0] wb_col_q, wb_col_d;
    logic             shift_en, emit;
    logic [COL_W-1:0] wr_col;

    // Configuration latched on SOF.
    logic [1:0]       mode_q, mode_d;
    logic [MAG_W-1:0] thresh_q, thresh_d;
    logic [CNT_W-1:0] minch_q, minch_d;
    logic             shift_q, shift_d;

    // Window: left and middle columns are shift registers; the right column
    // is the registered line-buffer read plus the newest pixel.
    logic [PIX_W-1:0] win_q [3][2];
    logic [PIX_W-1:0] win_d [3][2];
    logic [PIX_W-1:0] pix_q, pix_d;
    logic [PIX_W-1:0] right_col [3];

    // Stage 1 tags.
    logic             s1_valid_q, s1_valid_d, s1_sof_q, s1_sof_d, s1_border_q, s1_border_d;
    logic [1:0]       s1_mode_q, s1_mode_d;
    logic [MAG_W-1:0] s1_thresh_q, s1_thresh_d;
    logic [CNT_W-1:0] s1_minch_q, s1_minch_d;
    logic             s1_shift_q, s1_shift_d;

    // Stage 2 tags (gradients live in the per-channel blocks).
    logic             s2_valid_q, s2_valid_d, s2_sof_q, s2_sof_d;
    logic [PIX_W-1:0] s2_ctr_q, s2_ctr_d;
    logic [1:0]       s2_mode_q, s2_mode_d;
    logic [MAG_W-1:0] s2_thresh_q, s2_thresh_d;
    logic [CNT_W-1:0] s2_minch_q, s2_minch_d;
    logic             s2_shift_q, s2_shift_d;

    // Stage 3 / outputs.
    logic [PIX_W-1:0] pix_out_q, pix_out_d;
    logic             out_valid_q, out_valid_d, out_sof_q, out_sof_d;
    logic [NUM_CH-1:0] edge_vec;
    logic [PIX_W-1:0] ovl_vec, magq_vec;
    logic [CNT_W-1:0] edge_cnt;

    assign right_col[0] = lb1_rd_q;
    assign right_col[1] = lb0_rd_q;
    assign right_col[2] = pix_q;

    // Frame FSM, column/index counters and configuration capture.
    always_comb begin : ctrl_comb
        state_d  = state_q;
        idx_d    = idx_q;
        col_d    = col_q;
        row0_d   = row0_q;
        mode_d   = mode_q;
        thresh_d = thresh_q;
        minch_d  = minch_q;
        shift_d  = shift_q;
        shift_en = 1'b0;
        emit     = 1'b0;
        wr_col   = col_q;
        if (bus.pixInValid && bus.pixInSof) begin
            // SOF from any state starts (or restarts) a frame at index 0.
            state_d  = FILL;
            idx_d    = IDX_W'(1);
            col_d    = COL_W'(1);
            row0_d   = 1'b1;
            mode_d   = bus.mode;
            thresh_d = bus.edgeThresh;
            minch_d  = bus.minChannels;
            shift_d  = bus.shiftBrightness;
            shift_en = 1'b1;
            wr_col   = '0;
        end else if (bus.pixInValid && state_q != WAIT_SOF) begin
            shift_en = 1'b1;
            col_d    = (col_q == COL_W'(LINE_W - 1)) ? '0 : col_q + COL_W'(1);
            if (state_q == FILL) begin
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(LINE_W)) begin
                    state_d = RUN;
                end
            end else begin
                emit = 1'b1;
                // Centre column trails the input column by one; input col 0
                // closes the first centre row.
                if (col_q == '0) begin
                    row0_d = 1'b0;
                end
            end
        end
    end

    // Window shift and stage-1 tags.
    always_comb begin : stage1_comb
        win_d = win_q;
        pix_d = pix_q;
        if (shift_en) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = right_col[r];
            end
            pix_d = bus.pixIn;
        end
        wb_en_d     = shift_en;
        wb_col_d    = wr_col;
        s1_valid_d  = emit;
        s1_sof_d    = emit && row0_q && (col_q == COL_W'(1));
        s1_border_d = row0_q || (col_q < COL_W'(2));
        s1_mode_d   = mode_q;
        s1_thresh_d = thresh_q;
        s1_minch_d  = minch_q;
        s1_shift_d  = shift_q;
    end

    // Stage-2 tags travel with the gradients.
    always_comb begin : stage2_comb
        s2_valid_d  = s1_valid_q;
        s2_sof_d    = s1_sof_q;
        s2_ctr_d    = win_q[1][1];
        s2_mode_d   = s1_mode_q;
        s2_thresh_d = s1_thresh_q;
        s2_minch_d  = s1_minch_q;
        s2_shift_d  = s1_shift_q;
    end

    // Line-buffer RAMs: read-first at the write column; lb1 is refilled one
    // cycle later from the registered lb0 read, well before that column
    // comes round again.
    always_ff @(posedge clk25) begin : line_buf_ram
        if (shift_en) begin
            lb0_rd_q        <= lb0_mem[wr_col];
            lb1_rd_q        <= lb1_mem[wr_col];
            lb0_mem[wr_col] <= bus.pixIn;
        end
        if (wb_en_q) begin
            lb1_mem[wb_col_q] <= lb0_rd_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : gen_ch
            logic [CH_W-1:0]  lu, mu, ru, lm, rm, ld, md, rd, ctr;
            logic [MAG_W-1:0] gx_d, gy_d, gx_q, gy_q, ax, ay, mag;

            assign lu = win_q[0][0][gi*CH_W +: CH_W];
            assign mu = win_q[0][1][gi*CH_W +: CH_W];
            assign ru = right_col[0][gi*CH_W +: CH_W];
            assign lm = win_q[1][0][gi*CH_W +: CH_W];
            assign rm = right_col[1][gi*CH_W +: CH_W];
            assign ld = win_q[2][0][gi*CH_W +: CH_W];
            assign md = win_q[2][1][gi*CH_W +: CH_W];
            assign rd = right_col[2][gi*CH_W +: CH_W];

            // Two's-complement Sobel gradients; border centres contribute zero.
            always_comb begin : sobel_comb
                gx_d = '0;
                gy_d = '0;
                if (!s1_border_q) begin
                    gx_d = (MAG_W'(ru) + (MAG_W'(rm) << 1) + MAG_W'(rd))
                         - (MAG_W'(lu) + (MAG_W'(lm) << 1) + MAG_W'(ld));
                    gy_d = (MAG_W'(ld) + (MAG_W'(md) << 1) + MAG_W'(rd))
                         - (MAG_W'(lu) + (MAG_W'(mu) << 1) + MAG_W'(ru));
                end
            end

            // Stage-2 gradient registers.
            always_ff @(posedge clk25) begin : grad_regs
                if (!rst_n) begin
                    gx_q <= '0;
                    gy_q <= '0;
                end else begin
                    gx_q <= gx_d;
                    gy_q <= gy_d;
                end
            end

            assign ax  = gx_q[MAG_W-1] ? (~gx_q + MAG_W'(1)) : gx_q;
            assign ay  = gy_q[MAG_W-1] ? (~gy_q + MAG_W'(1)) : gy_q;
            assign mag = ax + ay;
            assign ctr = s2_ctr_q[gi*CH_W +: CH_W];
            assign edge_vec[gi] = (mag > s2_thresh_q);
            assign ovl_vec[gi*CH_W +: CH_W]  = edge_vec[gi] ? '1 : (s2_shift_q ? (ctr >> 1) : ctr);
            assign magq_vec[gi*CH_W +: CH_W] = mag[MAG_W-1:3];
        end
    endgenerate

    // Stage-3 output mux; the pixel holds between valid outputs.
    always_comb begin : stage3_comb
        edge_cnt = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            edge_cnt = edge_cnt + CNT_W'(edge_vec[k]);
        end
        out_valid_d = s2_valid_q;
        out_sof_d   = s2_valid_q && s2_sof_q;
        pix_out_d   = pix_out_q;
        if (s2_valid_q) begin
            case (s2_mode_q)
                2'b00:   pix_out_d = s2_ctr_q;
                2'b01:   pix_out_d = ovl_vec;
                2'b10:   pix_out_d = magq_vec;
                default: pix_out_d = (edge_cnt >= s2_minch_q) ? '1 : '0;
            endcase
        end
    end

    // All control, window and pipeline registers.
    always_ff @(posedge clk25) begin : main_regs
        if (!rst_n) begin
            state_q     <= WAIT_SOF;
            idx_q       <= '0;
            col_q       <= '0;
            row0_q      <= 1'b0;
            wb_en_q     <= 1'b0;
            wb_col_q    <= '0;
            mode_q      <= '0;
            thresh_q    <= '0;
            minch_q     <= '0;
            shift_q     <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= '0;
                win_q[r][1] <= '0;
            end
            pix_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_sof_q    <= 1'b0;
            s1_border_q <= 1'b0;
            s1_mode_q   <= '0;
            s1_thresh_q <= '0;
            s1_minch_q  <= '0;
            s1_shift_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_sof_q    <= 1'b0;
            s2_ctr_q    <= '0;
            s2_mode_q   <= '0;
            s2_thresh_q <= '0;
            s2_minch_q  <= '0;
            s2_shift_q  <= 1'b0;
            pix_out_q   <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            col_q       <= col_d;
            row0_q      <= row0_d;
            wb_en_q     <= wb_en_d;
            wb_col_q    <= wb_col_d;
            mode_q      <= mode_d;
            thresh_q    <= thresh_d;
            minch_q     <= minch_d;
            shift_q     <= shift_d;
            win_q       <= win_d;
            pix_q       <= pix_d;
            s1_valid_q  <= s1_valid_d;
            s1_sof_q    <= s1_sof_d;
            s1_border_q <= s1_border_d;
            s1_mode_q   <= s1_mode_d;
            s1_thresh_q <= s1_thresh_d;
            s1_minch_q  <= s1_minch_d;
            s1_shift_q  <= s1_shift_d;
            s2_valid_q  <= s2_valid_d;
            s2_sof_q    <= s2_sof_d;
            s2_ctr_q    <= s2_ctr_d;
            s2_mode_q   <= s2_mode_d;
            s2_thresh_q <= s2_thresh_d;
            s2_minch_q  <= s2_minch_d;
            s2_shift_q  <= s2_shift_d;
            pix_out_q   <= pix_out_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
        end
    end

    assign bus.pixOut      = pix_out_q;
    assign bus.pixOutValid = out_valid_q;
    assign bus.pixOutSof   = out_sof_q;
endmodule

// File: tb/tb_edge_window_pipe.sv
// Randomized bench for edge_window_pipe (LINE_W=8) against a frame-level
// reference model: each accepted beat stores its pixel at its frame index,
// and every beat past LINE_W+1 predicts the pixel for centre i-LINE_W-1,
// due on the outputs two further clock edges after the accepting edge.
module tb_edge_window_pipe;
    localparam int CH_W   = 4;
    localparam int NUM_CH = 3;
    localparam int LINE_W = 8;
    localparam int CNT_W  = 2;
    localparam int MAXC   = 8192;
    localparam int MAXF   = 1024;

    logic clk25 = 1'b0;
    logic rst_n = 1'b0;
    always #20 clk25 = ~clk25;

    edge_window_pipe_if #(.CH_W(CH_W), .NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    edge_window_pipe #(.CH_W(CH_W), .NUM_CH(NUM_CH), .LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
        .clk25 (clk25),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Expected outputs indexed by the clock edge after which they are visible.
    int exp_v [MAXC];
    int exp_s [MAXC];
    int exp_p [MAXC];

    // Model state: current frame pixels and the config latched at its SOF.
    int frame [MAXF];
    bit m_in_frame = 1'b0;
    int m_idx = 0;
    int m_mode = 0, m_thr = 0, m_minc = 0, m_shift = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int chan(int idx, int ch);
        return (frame[idx] >> (CH_W * ch)) & 15;
    endfunction

    function automatic int absi(int x);
        return (x < 0) ? -x : x;
    endfunction

    // Resolved pixel for frame centre index c under the latched config.
    function automatic int ref_pix(int c);
        int row, col, res, cnt, base;
        bit border;
        row = c / LINE_W;
        col = c % LINE_W;
        border = (row == 0) || (col == 0) || (col == LINE_W - 1);
        res = 0;
        cnt = 0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            int ctr, gx, gy, mag, v;
            bit is_edge;
            ctr = chan(c, ch);
            mag = 0;
            if (!border) begin
                base = c;
                gx = (chan(base - LINE_W + 1, ch) + 2 * chan(base + 1, ch) + chan(base + LINE_W + 1, ch))
                   - (chan(base - LINE_W - 1, ch) + 2 * chan(base - 1, ch) + chan(base + LINE_W - 1, ch));
                gy = (chan(base + LINE_W - 1, ch) + 2 * chan(base + LINE_W, ch) + chan(base + LINE_W + 1, ch))
                   - (chan(base - LINE_W - 1, ch) + 2 * chan(base - LINE_W, ch) + chan(base - LINE_W + 1, ch));
                mag = absi(gx) + absi(gy);
            end
            is_edge = (mag > m_thr);
            if (is_edge) cnt++;
            case (m_mode)
                0: v = ctr;
                1: v = is_edge ? 15 : (m_shift != 0 ? ctr / 2 : ctr);
                2: v = mag / 8;
                default: v = 0;
            endcase
            res = res | (v << (CH_W * ch));
        end
        if (m_mode == 3) res = (cnt >= m_minc) ? 'hFFF : 0;
        return res;
    endfunction

    // Model update for the edge numbered k, using the inputs it will sample.
    task automatic model_step(input int k);
        if (!rst_n) begin
            for (int j = k; j <= k + 2; j++) begin
                exp_v[j] = 0;
                exp_s[j] = 0;
                exp_p[j] = 0;
            end
            m_in_frame = 1'b0;
            return;
        end
        exp_v[k+2] = 0;
        exp_s[k+2] = 0;
        if (bus.pixInValid) begin
            if (bus.pixInSof) begin
                m_in_frame = 1'b1;
                m_idx      = 0;
                frame[0]   = int'(bus.pixIn);
                m_mode     = int'(bus.mode);
                m_thr      = int'(bus.edgeThresh);
                m_minc     = int'(bus.minChannels);
                m_shift    = int'(bus.shiftBrightness);
            end else if (m_in_frame) begin
                m_idx++;
                if (m_idx < MAXF) frame[m_idx] = int'(bus.pixIn);
                if (m_idx >= LINE_W + 1) begin
                    exp_v[k+2] = 1;
                    exp_s[k+2] = (m_idx == LINE_W + 1) ? 1 : 0;
                    exp_p[k+2] = ref_pix(m_idx - LINE_W - 1);
                end
            end
        end
    endtask

    // One clock: drive at negedge, predict, sample one unit after posedge.
    task automatic tick(input logic v, input logic s, input logic [11:0] p, input logic rst);
        @(negedge clk25);
        if (cyc + 3 >= MAXC) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
            $fatal(1);
        end
        rst_n           = rst;
        bus.pixInValid  = v;
        bus.pixInSof    = s;
        bus.pixIn       = p;
        model_step(cyc + 1);
        @(posedge clk25);
        cyc++;
        #1;
        check("valid", 32'(bus.pixOutValid), 32'(exp_v[cyc]));
        check("sof", 32'(bus.pixOutSof), 32'(exp_s[cyc]));
        if (exp_v[cyc] != 0) check("pix", 32'(bus.pixOut), 32'(exp_p[cyc]));
        if (bus.pixOutValid) $display("out cyc=%0d pix=%03h sof=%0b", cyc, bus.pixOut, bus.pixOutSof);
    endtask

    function automatic logic [11:0] gen(int pat, int i);
        int col;
        col = i % LINE_W;
        case (pat)
            0: return 12'(i);
            1: return (col < 4) ? 12'h222 : 12'hEEE;
            2: return (col < 4) ? 12'h000 : 12'hFFF;
            3: return (col < 4) ? 12'h200 : 12'hE00;
            default: return 12'($urandom);
        endcase
    endfunction

    // bub: 0 none, 1 a bubble every third cycle, 2 random bubbles.
    task automatic send_frame(input int nbeats, input int pat, input int bub,
                              input int md, input int thr, input int minc, input int sh);
        for (int i = 0; i < nbeats; i++) begin
            if ((bub == 1 && (i % 2 == 0) && i > 0) || (bub == 2 && $urandom_range(0, 3) == 0))
                tick(1'b0, 1'($urandom), 12'($urandom), 1'b1);
            if (i == 0) begin
                bus.mode            = 2'(md);
                bus.edgeThresh      = 7'(thr);
                bus.minChannels     = 2'(minc);
                bus.shiftBrightness = 1'(sh);
            end else begin
                bus.mode            = 2'($urandom);
                bus.edgeThresh      = 7'($urandom);
                bus.minChannels     = 2'($urandom);
                bus.shiftBrightness = 1'($urandom);
            end
            tick(1'b1, (i == 0), gen(pat, i), 1'b1);
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 12'($urandom), 1'b1);
    endtask

    initial begin
        bus.pixInValid      = 1'b0;
        bus.pixInSof        = 1'b0;
        bus.pixIn           = '0;
        bus.mode            = '0;
        bus.edgeThresh      = '0;
        bus.minChannels     = '0;
        bus.shiftBrightness = 1'b0;

        // Reset (SOF beats during reset are ignored), then idle beats without SOF.
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 12'($urandom), 1'b0);
        check("rst_pix", 32'(bus.pixOut), 32'h0);
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 12'($urandom), 1'b1);
        check("idle_pix", 32'(bus.pixOut), 32'h0);

        // Directed frames from the plan.
        send_frame(40, 0, 0, 0, 0, 0, 0);   drain(4);
        send_frame(32, 1, 0, 1, 8, 0, 1);   drain(4);
        send_frame(32, 2, 0, 2, 8, 0, 0);   drain(4);
        send_frame(32, 3, 0, 3, 8, 2, 0);   drain(4);
        send_frame(32, 3, 0, 3, 8, 1, 0);   drain(4);

        // Bubbles, then a restart at index 12 into a different mode.
        send_frame(32, 0, 1, 0, 0, 0, 0);
        send_frame(12, 4, 1, 1, 20, 0, 1);
        send_frame(40, 1, 1, 2, 8, 0, 0);   drain(4);

        // Mid-frame reset, stray beats in WAIT_SOF, then a fresh frame.
        send_frame(30, 4, 2, 0, 0, 0, 0);
        tick(1'b1, 1'b0, 12'($urandom), 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 12'($urandom), 1'b1);
        send_frame(24, 4, 0, 1, 30, 0, 1);  drain(4);

        // Randomized frames with random configuration and bubbles.
        for (int f = 0; f < 10; f++) begin
            int rows, pat;
            rows = $urandom_range(2, 8);
            pat  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 4;
            send_frame(rows * LINE_W + $urandom_range(0, 7), pat, 2,
                       $urandom_range(0, 3), $urandom_range(0, 100),
                       $urandom_range(0, 3), $urandom_range(0, 1));
            drain($urandom_range(0, 4));
        end
        drain(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
